traffic_request_arbiter: RTL and testbench
==========================================

Name: traffic_request_arbiter

Overview:
- Collects pedestrian and emergency requests from all four approaches (N=0, E=1, S=2, W=3).
- Arbitrates them: emergency beats pedestrian, with round-robin among pedestrians.
- Hands one request at a time to the intersection light FSM over a valid/ready handshake, then enforces the service window and an inter-request gap.
- Sits between the button/sensor front end and the light sequencer.

Parameters:
- ACK_TIMEOUT, 64: max cycles req_valid may wait for req_ready before abandoning the offer.
- TMR_W, 8: width of the service and gap timers and of the time inputs.

Ports:
- clk  in  1: clock.
- reset  in  1: synchronous, active-low reset.
- ped_btn  in  4: pedestrian buttons per direction, level; rising edge registers a request.
- em_btn  in  4: emergency requests per direction, level; rising edge registers a request.
- ped_time  in  TMR_W: pedestrian service duration in cycles (0 treated as 1).
- gap_time  in  TMR_W: minimum idle cycles after a service (0 = no gap).
- req_ready  in  1: light FSM accepts the offered request.
- svc_done  in  1: light FSM reports service complete (one-cycle pulse).
- req_valid  out  1: request offered.
- req_type  out  1: 0 = pedestrian, 1 = emergency.
- req_dir  out  2: direction of offered request.
- pend_ped  out  4: pending pedestrian bits.
- pend_em  out  4: pending emergency bits.
- busy  out  1: state is not IDLE.
- timeout_err  out  1: one-cycle pulse on handshake timeout.
- svc_abort  out  1: one-cycle pulse on preempted pedestrian service; always 0 unless the optional feature is enabled.

Behaviour:
- Reset (reset=0 at clk edge): all outputs 0, pending bits 0, button edge registers 0, round-robin pointer 0, state IDLE. Reset mid-operation drops any offer immediately.
- Edge detect: a button is registered previous cycle. A rising edge sets its pending bit on the next edge.
- Pending bit clear: only on handshake acceptance of that request. If set and clear hit the same bit in the same cycle, set wins.
- State machine (states: IDLE, OFFER, SERVICE, GAP):
  - IDLE: if any pend_em, select lowest-index emergency direction. Else if any pend_ped, select the first pending direction starting at rr_ptr, wrapping 3->0. Register req_dir/req_type, assert req_valid, go OFFER. Nothing pending: stay.
  - Latency: button rise sampled at edge t -> pending at t+1 -> req_valid at t+2.
  - OFFER: req_valid, req_dir and req_type are held stable until req_valid&req_ready. No re-arbitration during OFFER.
  - OFFER handshake: clear the accepted pending bit; req_valid=0 next cycle; for pedestrian, rr_ptr = req_dir+1 mod 4; go SERVICE. Pedestrian loads the timer with max(ped_time,1).
  - OFFER timeout: if ACK_TIMEOUT cycles elapse without ready, pulse timeout_err, drop req_valid, return IDLE. The pending bit is kept.
  - SERVICE, pedestrian: timer decrements each cycle; ends when the timer reaches 0 or on svc_done, whichever is first.
  - SERVICE, emergency: ends only on svc_done.
  - SERVICE end: load the gap timer with gap_time and go GAP; if gap_time=0, go directly to IDLE.
  - GAP: count down to 0, then IDLE. Any pend_em bit set during GAP ends GAP immediately (IDLE next cycle).
- Presses during SERVICE or GAP are registered normally, including for the direction being served; that request is served again later.
- svc_done outside SERVICE is ignored.
- Timer arithmetic is unsigned TMR_W. Timers never wrap below 0.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: ARB_EM_PREEMPT_EN.
- Defined: while SERVICE is serving a pedestrian, any pend_em bit set aborts it. svc_abort pulses for one cycle, the gap is skipped, state goes IDLE, and the emergency is offered the following cycle.
- Undefined: the pedestrian service runs to completion; svc_abort is tied 0.

Test Plan:
- Reset then ped_btn[2] rise with req_ready=1, ped_time=5, gap_time=3 -> req_valid at t+2 with dir=2, type=0; pend_ped[2] clears; busy for 5+3 cycles; IDLE after.
- ped_btn[1] and ped_btn[3] rise together, then em_btn[0] rises before the first offer -> offers in order em dir0, ped dir1, ped dir3; next ped press at dir1 after dir3 is served without wraparound error.
- req_ready held 0 for 70 cycles (ACK_TIMEOUT=64) -> timeout_err pulses once at the 64th waiting cycle; req_valid drops; pend bit retained; re-offered on the next IDLE cycle.
- Emergency accepted, svc_done asserted after 20 cycles, gap_time=0 -> IDLE the cycle after svc_done; ped_time is ignored.
- With ARB_EM_PREEMPT_EN, em_btn[3] rises during pedestrian SERVICE (ped_time=50) -> svc_abort pulse, emergency offer 2 cycles after pending; without the macro -> offer only after 50 cycles plus gap.
- Reset asserted during OFFER -> next cycle req_valid=0, pending bits 0, busy=0.

Source files
------------

// File: rtl/traffic_request_arbiter.sv
// Arbitrates pedestrian/emergency requests (emergency first, round-robin peds) into a valid/ready offer.
// Latency: button rise sampled at edge t -> pending at t+1 -> req_valid at t+2.
// Backpressure: offer held until req_ready, abandoned after ACK_TIMEOUT cycles; ARB_EM_PREEMPT_EN lets emergencies abort ped service.
module traffic_request_arbiter #(
    parameter int ACK_TIMEOUT = 64,
    parameter int TMR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ped_btn,
    input  logic [3:0]       em_btn,
    input  logic [TMR_W-1:0] ped_time,
    input  logic [TMR_W-1:0] gap_time,
    input  logic             req_ready,
    input  logic             svc_done,
    output logic             req_valid,
    output logic             req_type,
    output logic [1:0]       req_dir,
    output logic [3:0]       pend_ped,
    output logic [3:0]       pend_em,
    output logic             busy,
    output logic             timeout_err,
    output logic             svc_abort
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        ped_s_q, ped_s_d, ped_prev_q, ped_prev_d;
    logic [3:0]        em_s_q, em_s_d, em_prev_q, em_prev_d;
    logic [3:0]        pend_ped_q, pend_ped_d, pend_em_q, pend_em_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              req_valid_q, req_valid_d;
    logic              req_type_q, req_type_d;
    logic [1:0]        req_dir_q, req_dir_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        rise_ped, rise_em, clr_ped, clr_em;
    logic              preempt;
`ifdef ARB_EM_PREEMPT_EN
    logic              svc_abort_q, svc_abort_d;
`endif

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Scan downward so the candidate closest to ptr is the one left standing.
    function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (v[cand]) idx = cand;
        end
        return idx;
    endfunction

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        req_valid_d   = req_valid_q;
        req_type_d    = req_type_q;
        req_dir_d     = req_dir_q;
        timer_d       = timer_q;
        wait_d        = wait_q;
        timeout_err_d = 1'b0;
        clr_ped       = 4'b0;
        clr_em        = 4'b0;
        ped_s_d       = ped_btn;
        ped_prev_d    = ped_s_q;
        em_s_d        = em_btn;
        em_prev_d     = em_s_q;
        rise_ped      = ped_s_q & ~ped_prev_q;
        rise_em       = em_s_q & ~em_prev_q;
`ifdef ARB_EM_PREEMPT_EN
        svc_abort_d   = 1'b0;
        preempt       = !req_type_q && (pend_em_q != 4'b0);
`else
        preempt       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (pend_em_q != 4'b0) begin
                    req_dir_d   = lowest_set(pend_em_q);
                    req_type_d  = 1'b1;
                    req_valid_d = 1'b1;
                    state_d     = OFFER;
                end else if (pend_ped_q != 4'b0) begin
                    req_dir_d   = rr_pick(pend_ped_q, rr_ptr_q);
                    req_type_d  = 1'b0;
                    req_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = SERVICE;
                    if (req_type_q) begin
                        clr_em = 4'b1 << req_dir_q;
                    end else begin
                        clr_ped  = 4'b1 << req_dir_q;
                        rr_ptr_d = req_dir_q + 2'd1;
                        timer_d  = (ped_time == '0) ? TMR_W'(1) : ped_time;
                    end
                end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    req_valid_d   = 1'b0;
                    state_d       = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            SERVICE: begin
                if (preempt) begin
`ifdef ARB_EM_PREEMPT_EN
                    svc_abort_d = 1'b1;
`endif
                    state_d = IDLE;
                end else if (svc_done || (!req_type_q && timer_q <= TMR_W'(1))) begin
                    if (gap_time == '0) begin
                        timer_d = '0;
                        state_d = IDLE;
                    end else begin
                        timer_d = gap_time;
                        state_d = GAP;
                    end
                end else if (!req_type_q) begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            GAP: begin
                if (pend_em_q != 4'b0 || timer_q <= TMR_W'(1)) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh press outranks the clear of the same bit.
        pend_ped_d = (pend_ped_q & ~clr_ped) | rise_ped;
        pend_em_d  = (pend_em_q & ~clr_em) | rise_em;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            ped_s_q       <= '0;
            ped_prev_q    <= '0;
            em_s_q        <= '0;
            em_prev_q     <= '0;
            pend_ped_q    <= '0;
            pend_em_q     <= '0;
            rr_ptr_q      <= '0;
            req_valid_q   <= 1'b0;
            req_type_q    <= 1'b0;
            req_dir_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
            wait_q        <= '0;
`ifdef ARB_EM_PREEMPT_EN
            svc_abort_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ped_s_q       <= ped_s_d;
            ped_prev_q    <= ped_prev_d;
            em_s_q        <= em_s_d;
            em_prev_q     <= em_prev_d;
            pend_ped_q    <= pend_ped_d;
            pend_em_q     <= pend_em_d;
            rr_ptr_q      <= rr_ptr_d;
            req_valid_q   <= req_valid_d;
            req_type_q    <= req_type_d;
            req_dir_q     <= req_dir_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
            wait_q        <= wait_d;
`ifdef ARB_EM_PREEMPT_EN
            svc_abort_q   <= svc_abort_d;
`endif
        end
    end

    assign req_valid   = req_valid_q;
    assign req_type    = req_type_q;
    assign req_dir     = req_dir_q;
    assign pend_ped    = pend_ped_q;
    assign pend_em     = pend_em_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
`ifdef ARB_EM_PREEMPT_EN
    assign svc_abort   = svc_abort_q;
`else
    assign svc_abort   = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_request_arbiter.sv
// Directed self-checking bench for traffic_request_arbiter (default ACK_TIMEOUT=64, TMR_W=8).
module tb_traffic_request_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ped_btn, em_btn;
    logic [7:0] ped_time, gap_time;
    logic       req_ready, svc_done;
    logic       req_valid, req_type, busy, timeout_err, svc_abort;
    logic [1:0] req_dir;
    logic [3:0] pend_ped, pend_em;

    int checks = 0;
    int errors = 0;

    traffic_request_arbiter #(.ACK_TIMEOUT(64), .TMR_W(8)) dut (
        .clk(clk), .reset(reset), .ped_btn(ped_btn), .em_btn(em_btn),
        .ped_time(ped_time), .gap_time(gap_time), .req_ready(req_ready),
        .svc_done(svc_done), .req_valid(req_valid), .req_type(req_type),
        .req_dir(req_dir), .pend_ped(pend_ped), .pend_em(pend_em), .busy(busy),
        .timeout_err(timeout_err), .svc_abort(svc_abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !req_valid; i++) tick();
        checks++;
        if (req_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: req_valid=%b, required 1 within 20 cycles", name, req_valid);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && (busy || req_valid); i++) tick();
        checks++;
        if (busy !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b req_valid=%b, required both 0", name, busy, req_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ped_btn = '0; em_btn = '0; ped_time = '0; gap_time = '0;
        req_ready = 1'b0; svc_done = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_valid, req_type, req_dir, pend_ped, pend_em, busy, timeout_err, svc_abort} !== 15'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {req_valid, req_type, req_dir, pend_ped, pend_em, busy, timeout_err, svc_abort});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ped_basic();
        int cnt;
        ped_time = 8'd5; gap_time = 8'd3; req_ready = 1'b1;
        ped_btn = 4'b0100;
        tick();
        checks++;
        if (pend_ped !== 4'b0000) begin
            errors++; $display("FAIL ped_pend_early: got %b, required 0000", pend_ped);
        end
        tick();
        checks++;
        if (pend_ped !== 4'b0100 || req_valid !== 1'b0) begin
            errors++; $display("FAIL ped_pend_t1: pend=%b valid=%b, required 0100/0", pend_ped, req_valid);
        end
        tick();
        checks++;
        if (req_valid !== 1'b1 || req_dir !== 2'd2 || req_type !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ped_offer_t2: valid=%b dir=%0d type=%b busy=%b, required 1/2/0/1",
                     req_valid, req_dir, req_type, busy);
        end
        cnt = 1;
        tick();
        ped_btn = '0;
        checks++;
        if (req_valid !== 1'b0 || pend_ped !== 4'b0000) begin
            errors++; $display("FAIL ped_accept: valid=%b pend=%b, required 0/0000", req_valid, pend_ped);
        end
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
        // one OFFER cycle + 5 service + 3 gap
        checks++;
        if (cnt != 9) begin
            errors++; $display("FAIL ped_busy_len: got %0d cycles, required 9", cnt);
        end
    endtask

    task automatic test_priority_rr();
        logic [2:0] log_q[$];
        reset = 1'b0; tick(); reset = 1'b1;
        req_ready = 1'b1; svc_done = 1'b1; ped_time = 8'd2; gap_time = 8'd0;
        ped_btn = 4'b1010; em_btn = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 2) begin ped_btn = '0; em_btn = '0; end
            if (req_valid && req_ready) log_q.push_back({req_type, req_dir});
        end
        checks++;
        if (log_q.size() != 3) begin
            errors++; $display("FAIL prio_count: got %0d offers, required 3", log_q.size());
        end else begin
            checks++;
            if (log_q[0] !== 3'b100 || log_q[1] !== 3'b001 || log_q[2] !== 3'b011) begin
                errors++;
                $display("FAIL prio_order: got %b %b %b, required 100 001 011", log_q[0], log_q[1], log_q[2]);
            end
        end
        checks++;
        if (pend_ped !== 4'b0 || pend_em !== 4'b0) begin
            errors++; $display("FAIL prio_pend_clear: ped=%b em=%b, required 0/0", pend_ped, pend_em);
        end
        ped_btn = 4'b0010;
        wait_valid("rr_wrap_valid");
        checks++;
        if (req_dir !== 2'd1 || req_type !== 1'b0) begin
            errors++; $display("FAIL rr_wrap_dir: dir=%0d type=%b, required 1/0", req_dir, req_type);
        end
        ped_btn = '0;
        wait_idle("rr_wrap_idle");
        svc_done = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses, pulse_at;
        logic v64, v65, v66;
        logic [3:0] p65;
        req_ready = 1'b0; ped_time = 8'd1; gap_time = 8'd0;
        pulses = 0; pulse_at = -1; v64 = 1'bx; v65 = 1'bx; v66 = 1'bx; p65 = 'x;
        ped_btn = 4'b0001;
        wait_valid("to_first_valid");
        ped_btn = '0;
        for (int n = 2; n <= 70; n++) begin
            tick();
            if (timeout_err) begin pulses++; pulse_at = n; end
            if (n == 64) v64 = req_valid;
            if (n == 65) begin v65 = req_valid; p65 = pend_ped; end
            if (n == 66) v66 = req_valid;
        end
        checks++;
        if (pulses != 1 || pulse_at != 65) begin
            errors++; $display("FAIL to_pulse: %0d pulses at cycle %0d, required 1 at 65", pulses, pulse_at);
        end
        checks++;
        if (v64 !== 1'b1 || v65 !== 1'b0) begin
            errors++; $display("FAIL to_valid_drop: v64=%b v65=%b, required 1/0", v64, v65);
        end
        checks++;
        if (p65 !== 4'b0001) begin
            errors++; $display("FAIL to_pend_kept: got %b, required 0001", p65);
        end
        checks++;
        if (v66 !== 1'b1 || req_dir !== 2'd0) begin
            errors++; $display("FAIL to_reoffer: valid=%b dir=%0d, required 1/0", v66, req_dir);
        end
        req_ready = 1'b1;
        wait_idle("to_idle");
    endtask

    task automatic test_emergency();
        req_ready = 1'b1; ped_time = 8'd5; gap_time = 8'd0; svc_done = 1'b0;
        em_btn = 4'b0010;
        wait_valid("em_valid");
        checks++;
        if (req_type !== 1'b1 || req_dir !== 2'd1) begin
            errors++; $display("FAIL em_offer: type=%b dir=%0d, required 1/1", req_type, req_dir);
        end
        tick();
        em_btn = '0;
        repeat (19) tick();
        checks++;
        if (busy !== 1'b1 || pend_em !== 4'b0) begin
            errors++; $display("FAIL em_hold: busy=%b pend_em=%b, required 1/0000", busy, pend_em);
        end
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_valid !== 1'b0) begin
            errors++; $display("FAIL em_done: busy=%b valid=%b, required 0/0", busy, req_valid);
        end
    endtask

    task automatic test_preempt();
        int first_abort, aborts, first_valid, exp_abort, exp_valid, exp_aborts;
        logic [3:0] pem5;
        logic [1:0] vdir;
        logic vtype;
        req_ready = 1'b1; ped_time = 8'd50; gap_time = 8'd4; svc_done = 1'b0;
        first_abort = -1; aborts = 0; first_valid = -1; pem5 = 'x; vdir = 'x; vtype = 1'bx;
        ped_btn = 4'b0100;
        wait_valid("pre_ped_valid");
        tick();
        ped_btn = '0;
        for (int k = 1; k <= 70 && first_valid < 0; k++) begin
            tick();
            if (svc_abort) begin aborts++; if (first_abort < 0) first_abort = k; end
            if (req_valid) begin first_valid = k; vdir = req_dir; vtype = req_type; end
            if (k == 5) pem5 = pend_em;
            if (k == 3) em_btn = 4'b1000;
            if (k == 6) em_btn = '0;
        end
`ifdef ARB_EM_PREEMPT_EN
        exp_abort = 6; exp_aborts = 1; exp_valid = 7;
`else
        exp_abort = -1; exp_aborts = 0; exp_valid = 52;
`endif
        checks++;
        if (pem5 !== 4'b1000) begin
            errors++; $display("FAIL pre_pend: got %b, required 1000", pem5);
        end
        checks++;
        if (first_abort != exp_abort || aborts != exp_aborts) begin
            errors++;
            $display("FAIL pre_abort: first=%0d count=%0d, required %0d/%0d", first_abort, aborts, exp_abort, exp_aborts);
        end
        checks++;
        if (first_valid != exp_valid || vdir !== 2'd3 || vtype !== 1'b1) begin
            errors++;
            $display("FAIL pre_em_offer: at %0d dir=%0d type=%b, required %0d/3/1", first_valid, vdir, vtype, exp_valid);
        end
        tick();
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        wait_idle("pre_idle");
    endtask

    task automatic test_reset_in_offer();
        req_ready = 1'b0;
        ped_btn = 4'b0001; em_btn = 4'b0100;
        wait_valid("rst_offer_valid");
        checks++;
        if (req_type !== 1'b1 || req_dir !== 2'd2 || pend_ped !== 4'b0001) begin
            errors++;
            $display("FAIL rst_offer: type=%b dir=%0d pend_ped=%b, required 1/2/0001", req_type, req_dir, pend_ped);
        end
        reset = 1'b0; ped_btn = '0; em_btn = '0;
        tick();
        checks++;
        if (req_valid !== 1'b0 || pend_ped !== 4'b0 || pend_em !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b ped=%b em=%b busy=%b, required all 0", req_valid, pend_ped, pend_em, busy);
        end
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_after: valid=%b busy=%b, required 0/0", req_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ped_basic();
        wait_idle("ped_idle");
        test_priority_rr();
        test_timeout();
        test_emergency();
        test_preempt();
        test_reset_in_offer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
